// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver with a one-entry
// valid/ready holding register, framing-error and overrun pulses.
module serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       serialin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  sync;
    logic        s_in;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;

    assign s_in = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], serialin};
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!s_in)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= s_in ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt        <= '0;
                        shreg[idx] <= s_in;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (s_in) begin
                            // Back to IDLE at mid stop bit so the next start edge is seen.
                            state <= IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (s_in)
                        state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames into serial_rx, scoreboard queue
// checked by a negedge monitor on every valid&ready transfer.
module tb_serial_rx;

    localparam int C  = 16;
    localparam int HB = 8;
    localparam int LAT = 3 + HB + 9 * C;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       serialin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fe_n = 0;
    int   ov_n = 0;
    int   fe_cyc = -1;
    int   ov_cyc = -1;
    exp_t exp_q[$];
    exp_t e_mon;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = 8'h00;

    serial_rx #(.CLKS_PER_BIT(C), .HALF_BIT(HB)) dut (
        .clk(clk),
        .rstn(rstn),
        .serialin(serialin),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each transfer, tracks pulses.
    always @(negedge clk) begin
        if (!rstn) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                checks++;
                if (!rx_valid || rx_data !== pd) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h",
                             rx_valid, rx_data, pd);
                end
            end
            if (frame_err) begin
                fe_n++;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_n++;
                ov_cyc = cyc;
            end
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, required none", rx_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (rx_data !== e_mon.data) begin
                        errors++;
                        $display("FAIL rx_data: got %h, required %h", rx_data, e_mon.data);
                    end
                    if (e_mon.cyc >= 0) begin
                        checks++;
                        if (cyc != e_mon.cyc) begin
                            errors++;
                            $display("FAIL latency: byte %h at cycle %0d, required %0d",
                                     e_mon.data, cyc, e_mon.cyc);
                        end
                    end
                end
            end
            pv = rx_valid;
            pr = rx_ready;
            pd = rx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serialin = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            serialin = b[i];
            tick(C);
        end
        serialin = stop;
        tick(C);
    endtask

    task automatic send_exp(input logic [7:0] b, input bit timed);
        exp_t e;
        e.data = b;
        e.cyc  = timed ? cyc + LAT : -1;
        exp_q.push_back(e);
        send_frame(b, 1'b1);
    endtask

    task automatic drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++)
            tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bytes still pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ov0;
        int t0;

        rstn     = 1'b0;
        serialin = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);
        rstn = 1'b1;
        tick(5);

        // Single byte with exact latency.
        fe0 = fe_n;
        ov0 = ov_n;
        send_exp(8'hA5, 1'b1);
        tick(4);
        drain("drain_a5", 50);
        chk("a5_no_ferr", fe_n - fe0, 0);
        chk("a5_no_ovr", ov_n - ov0, 0);
        chk("a5_valid_low", int'(rx_valid), 0);

        // Back-to-back frames, 160 cycles apart.
        send_exp(8'h00, 1'b1);
        send_exp(8'hFF, 1'b1);
        send_exp(8'h55, 1'b1);
        tick(8);
        drain("drain_b2b", 50);
        chk("b2b_no_ferr", fe_n - fe0, 0);

        // Overrun: holding register full.
        rx_ready = 1'b0;
        ov0 = ov_n;
        send_exp(8'h12, 1'b0);
        tick(10);
        t0 = cyc;
        send_frame(8'h34, 1'b1);
        tick(10);
        chk("ovr_count", ov_n - ov0, 1);
        chk("ovr_cycle", ov_cyc, t0 + LAT);
        chk("ovr_valid_held", int'(rx_valid), 1);
        chk("ovr_data_held", int'(rx_data), 8'h12);
        rx_ready = 1'b1;
        drain("drain_ovr", 10);
        tick(2);
        chk("ovr_valid_clear", int'(rx_valid), 0);

        // Framing error followed by a long break.
        fe0 = fe_n;
        t0 = cyc;
        send_frame(8'h3C, 1'b0);
        tick(100 * C);
        chk("brk_busy", int'(busy), 1);
        chk("brk_ferr_count", fe_n - fe0, 1);
        chk("brk_ferr_cycle", fe_cyc, t0 + LAT);
        serialin = 1'b1;
        tick(6);
        chk("brk_idle", int'(busy), 0);
        tick(C);
        send_exp(8'h7E, 1'b1);
        tick(4);
        drain("drain_7e", 50);
        chk("brk_ferr_final", fe_n - fe0, 1);

        // Glitch on the idle line is rejected.
        serialin = 1'b0;
        tick(5);
        chk("glitch_busy", int'(busy), 1);
        serialin = 1'b1;
        tick(20);
        chk("glitch_idle", int'(busy), 0);
        chk("glitch_no_valid", int'(rx_valid), 0);

        // Reset in the middle of a frame, with a byte held.
        fe0 = fe_n;
        ov0 = ov_n;
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        tick(4);
        chk("pre_rst_valid", int'(rx_valid), 1);
        serialin = 1'b0;
        tick(C);
        serialin = 1'b1;
        tick(40);
        chk("mid_data_busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        tick(3);
        rstn = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        send_exp(8'hC3, 1'b1);
        tick(4);
        drain("drain_c3", 50);
        chk("rst_no_ferr", fe_n - fe0, 0);
        chk("rst_no_ovr", ov_n - ov0, 0);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
